mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 92 +++++++++
 tb/tb_mult_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one multiplier between two requesters; optional RUN timeout via MULT_ARB_TIMEOUT_EN
module mult_arbiter #(
  parameter int inSize = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [inSize-1:0]     req0_a,
  input  logic [inSize-1:0]     req0_b,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [inSize-1:0]     req1_a,
  input  logic [inSize-1:0]     req1_b,
  output logic                  req1_ready,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [2*inSize-1:0]   rsp_product,
  output logic                  rsp_err,
  output logic                  mul_clr,
  output logic                  mul_en,
  output logic [inSize-1:0]     mul_A,
  output logic [inSize-1:0]     mul_B,
  input  logic [2*inSize-1:0]   mul_product,
  input  logic                  mul_valid
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t state;
  logic last_grant, grant, id, done;
  // round-robin pick: contention goes to whoever was not served last
  always_comb grant = (req0_valid && req1_valid) ? !last_grant : req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign done = mul_valid || (cnt == CW'(TIMEOUT_CYC - 1));
  // RUN-cycle counter; an on-time mul_valid always beats the timeout
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt <= (state == RUN) ? cnt + 1'b1 : '0;
      if (state == RUN && done) rsp_err <= !mul_valid;
    end
`else
  logic unused_timeout;
  assign done = mul_valid;
  assign rsp_err = 1'b0;
  assign unused_timeout = TIMEOUT_CYC > 0;
`endif
  // operation sequencer with registered multiplier and response controls
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      id <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_product <= '0;
      mul_clr <= 1'b0;
      mul_en <= 1'b0;
      mul_A <= '0;
      mul_B <= '0;
    end else begin
      mul_clr <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          mul_A <= grant ? req1_a : req0_a;
          mul_B <= grant ? req1_b : req0_b;
          id <= grant;
          last_grant <= grant;
          mul_clr <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          mul_en <= 1'b1;
          state <= RUN;
        end
        RUN: if (done) begin
          mul_en <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_id <= id;
          rsp_product <= mul_valid ? mul_product : '0;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter with behavioural multiplier and arbitration model
module tb_mult_arbiter;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic rsp_valid, rsp_id, rsp_err, mul_clr, mul_en, mul_valid;
  logic [7:0] rsp_product, mul_product;
  logic [3:0] mul_A, mul_B;
  int tests = 0, errs = 0, cyc = 0, k = 1, mcnt = 0;
  bit stuck = 0, last = 1;
  typedef struct {logic id; logic [7:0] p; logic e; int c;} exp_t;
  exp_t q[$];
  logic [7:0] lp = 0;
  logic lid = 0, le = 0;

  mult_arbiter #(.inSize(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_clr(mul_clr), .mul_en(mul_en), .mul_A(mul_A), .mul_B(mul_B),
    .mul_product(mul_product), .mul_valid(mul_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mcnt <= (rst || mul_clr) ? 0 : mul_en ? mcnt + 1 : mcnt;
  assign mul_product = {4'b0, mul_A} * {4'b0, mul_B};
  assign mul_valid = mul_en && !stuck && (mcnt == k);

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string nm);
    tests++;
    errs++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  always @(negedge clk) begin
    exp_t x;
    logic win;
    logic [7:0] a, b;
    if (rst) begin
      lp = 0; lid = 0; le = 0;
    end else begin
      if (req0_ready && req1_ready) fail("both_ready");
      if ((req0_ready || req1_ready) && q.size() != 0) fail("ready_while_busy");
      if (q.size() == 0 && (req0_valid || req1_valid)) begin
        win = (req0_valid && req1_valid) ? !last : req1_valid;
        chk("grant", {req1_ready, req0_ready}, win ? 2'b10 : 2'b01);
        if (req0_ready || req1_ready) begin
          a = win ? {4'b0, req1_a} : {4'b0, req0_a};
          b = win ? {4'b0, req1_b} : {4'b0, req0_b};
          x.id = win; x.p = a * b; x.e = 0; x.c = cyc + 3 + k;
`ifdef MULT_ARB_TIMEOUT_EN
          if (stuck || k >= TO) begin x.p = 0; x.e = 1; x.c = cyc + 2 + TO; end
`endif
          q.push_back(x);
          last = win;
        end
      end
      if (q.size() != 0 && cyc > q[0].c) begin
        fail("rsp_missing");
        void'(q.pop_front());
      end
      if (rsp_valid) begin
        if (q.size() == 0) fail("rsp_unexpected");
        else begin
          x = q.pop_front();
          chk("rsp_id", rsp_id, x.id);
          chk("rsp_product", rsp_product, x.p);
          chk("rsp_err", rsp_err, x.e);
          chk("rsp_cycle", cyc, x.c);
          lp = x.p; lid = x.id; le = x.e;
        end
      end else begin
        chk("hold_product", rsp_product, lp);
        chk("hold_id", rsp_id, lid);
        chk("hold_err", rsp_err, le);
      end
    end
  end

  task automatic issue(input bit n, input logic [3:0] a, input logic [3:0] b);
    int t = 0;
    if (n) begin req1_a = a; req1_b = b; req1_valid = 1; end
    else begin req0_a = a; req0_b = b; req0_valid = 1; end
    @(negedge clk);
    while (!(n ? req1_ready : req0_ready) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) fail("accept_wait");
    @(posedge clk); #1;
    if (n) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (q.size() != 0) fail("drain_wait");
    repeat (2) @(negedge clk);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    rst = 1; q.delete(); last = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    bit [1:0] sel;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_product", rsp_product, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_mul_clr", mul_clr, 0);
    chk("rst_mul_ab", {mul_A, mul_B}, 0);
    k = 1;
    issue(0, 3, 2); drain();
    rst_pulse();
    fork issue(0, 5, 7); issue(1, 4, 4); join
    drain();
    issue(1, 15, 15); issue(1, 0, 9); drain();
    k = 3;
    issue(0, 6, 6);
    rst_pulse();
    @(negedge clk);
    chk("rst_run_mul_en", mul_en, 0);
    chk("rst_run_rsp_valid", rsp_valid, 0);
    repeat (8) @(negedge clk);
    issue(0, 2, 3); drain();
    k = 12;
    issue(1, 7, 9); drain();
`ifdef MULT_ARB_TIMEOUT_EN
    stuck = 1;
    issue(0, 9, 9); drain();
    stuck = 0; k = TO - 1;
    issue(1, 13, 11); drain();
    k = TO;
    issue(0, 4, 5); drain();
`endif
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 5);
      sel = 2'($urandom_range(0, 2));
      if (sel == 2) fork
        issue(0, 4'($urandom), 4'($urandom));
        issue(1, 4'($urandom), 4'($urandom));
      join
      else issue(sel[0], 4'($urandom), 4'($urandom));
      drain();
    end
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
